// File: rtl/usb_tx.sv
// usb_tx: frame transmitter for the session link.
// Sends SYNC, PID, optional RAM payload and XOR checksum over a valid/ready byte port.
`timescale 1ns/1ps
module usb_tx #(
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter logic [11:0] LEN_DATA  = 12'h240,
    parameter logic [11:0] LEN_PARAM = 12'h010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_tx,
    output logic        fd_tx,
    input  logic [3:0]  tx_btype,
    input  logic [11:0] tx_ram_init,
    output logic [11:0] ram_addr,
    input  logic [7:0]  ram_rxd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    // Bag type codes
    localparam logic [3:0] BAG_INIT  = 4'b0000;
    localparam logic [3:0] BAG_ACK   = 4'b0001;
    localparam logic [3:0] BAG_NAK   = 4'b0010;
    localparam logic [3:0] BAG_DATA0 = 4'b0011;
    localparam logic [3:0] BAG_DATA1 = 4'b0100;
    localparam logic [3:0] BAG_DIDX  = 4'b0101;
    localparam logic [3:0] BAG_DTEMP = 4'b1010;
    localparam logic [3:0] BAG_STL   = 4'b1011;
    localparam logic [3:0] BAG_ERROR = 4'b1100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PREP,
        S_SYNC,
        S_PID,
        S_RADDR,
        S_RWAIT,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  btype;
    logic [11:0] base;
    logic [11:0] len;
    logic [11:0] count;
    logic [11:0] count_nxt;
    logic [7:0]  csum;
    logic [7:0]  byte_q;
    logic [7:0]  pid;
    logic        xfer;
    logic        last;

    // Payload-carrying bag types; everything else is header only.
    function automatic logic is_data(input logic [3:0] b);
        return (b == BAG_DATA0) || (b == BAG_DATA1) ||
               ((b >= BAG_DIDX) && (b <= BAG_DTEMP));
    endfunction

    // Payload length for a bag type (zero for header-only types).
    function automatic logic [11:0] len_of(input logic [3:0] b);
        logic [11:0] l;
        l = 12'h000;
        if ((b == BAG_DATA0) || (b == BAG_DATA1))
            l = LEN_DATA;
        else if (is_data(b))
            l = LEN_PARAM;
        return l;
    endfunction

    assign pid       = {~btype, btype};
    assign xfer      = tx_valid && tx_ready;
    assign count_nxt = count + 12'd1;
    assign last      = (count_nxt == len);
    assign ram_addr  = base + count;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (fs_tx) state_nxt = S_PREP;
            S_PREP:  state_nxt = (tx_btype == BAG_INIT) ? S_DONE : S_SYNC;
            S_SYNC:  if (xfer) state_nxt = S_PID;
            S_PID: begin
                if (xfer)
                    state_nxt = is_data(btype) ? S_RADDR : S_DONE;
            end
            S_RADDR: state_nxt = S_RWAIT;
            S_RWAIT: state_nxt = S_DATA;
            S_DATA: begin
                if (xfer)
                    state_nxt = last ? S_CSUM : S_RADDR;
            end
            S_CSUM:  if (xfer) state_nxt = S_DONE;
            S_DONE:  if (!fs_tx) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; all outputs depend only on registered state
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        fd_tx    = 1'b0;
        unique case (state)
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
            end
            S_PID: begin
                tx_valid = 1'b1;
                tx_data  = pid;
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = byte_q;
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
            end
            S_DONE:  fd_tx = 1'b1;
            default: ;
        endcase
    end

    // Frame context, payload byte, counter and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            btype  <= BAG_INIT;
            base   <= 12'h000;
            len    <= 12'h000;
            count  <= 12'h000;
            csum   <= 8'h00;
            byte_q <= 8'h00;
        end else begin
            unique case (state)
                S_PREP: begin
                    btype <= tx_btype;
                    base  <= tx_ram_init;
                    len   <= len_of(tx_btype);
                    count <= 12'h000;
                    csum  <= 8'h00;
                end
                S_PID: begin
                    if (xfer) csum <= pid;
                end
                S_RWAIT: byte_q <= ram_rxd;
                S_DATA: begin
                    if (xfer) begin
                        csum  <= csum ^ byte_q;
                        count <= count_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Codes recognised but carrying no payload; kept for readability of the map.
    logic unused_codes;
    assign unused_codes = ^{BAG_ACK, BAG_NAK, BAG_STL, BAG_ERROR};

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed self-checking bench for usb_tx.
// Bytes are logged at the falling edge; stimulus steps on posedge+1.
`timescale 1ns/1ps
module tb_usb_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_tx;
    logic        fd_tx;
    logic [3:0]  tx_btype;
    logic [11:0] tx_ram_init;
    logic [11:0] ram_addr;
    logic [7:0]  ram_rxd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [7:0]  mem [0:4095];

    int          checks   = 0;
    int          failures = 0;
    int          stall_cnt = 0;

    logic [7:0]  q[$];
    logic [7:0]  q_full[$];
    logic [11:0] aq[$];
    bit          cap_en = 1'b0;
    bit          stalled = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    usb_tx dut (
        .clk         (clk),
        .rst         (rst),
        .fs_tx       (fs_tx),
        .fd_tx       (fd_tx),
        .tx_btype    (tx_btype),
        .tx_ram_init (tx_ram_init),
        .ram_addr    (ram_addr),
        .ram_rxd     (ram_rxd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rxd <= mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!cap_en || rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                assert (tx_valid === 1'b1 && tx_data === stall_data) else begin
                    failures++;
                    $error("FAIL stall_hold observed=%0h/%0h expected=1/%0h",
                           tx_valid, tx_data, stall_data);
                end
            end
            if (tx_valid && tx_ready) q.push_back(tx_data);
            if (q.size() >= 2 && (aq.size() == 0 || aq[aq.size()-1] != ram_addr))
                aq.push_back(ram_addr);
            stalled = tx_valid && !tx_ready;
            if (stalled) stall_cnt++;
            stall_data = tx_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] aq_at(input int i);
        return (i < aq.size()) ? aq[i] : 12'hxxx;
    endfunction

    task automatic run_frame(input logic [3:0] bt, input logic [11:0] base,
                             input bit thr, input bit drop_fs,
                             input int budget, output int n);
        q.delete();
        aq.delete();
        cap_en      = 1'b1;
        tx_btype    = bt;
        tx_ram_init = base;
        fs_tx       = 1'b1;
        tx_ready    = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        while (!fd_tx && n < budget) begin
            tick;
            n++;
            if (n == 3) begin
                tx_btype    = ~bt;
                tx_ram_init = ~base;
                if (drop_fs) fs_tx = 1'b0;
            end
            tx_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("fd_reached", fd_tx, 1'b1);
        tx_ready = 1'b1;
        if (drop_fs) begin
            tick;
            chk("done_one_cycle", fd_tx, 1'b0);
        end else begin
            tick;
            tick;
            chk("fd_hold", fd_tx, 1'b1);
            fs_tx = 1'b0;
            tick;
            chk("fd_clear", fd_tx, 1'b0);
        end
        cap_en = 1'b0;
        tick;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] pid,
                               input logic [11:0] base, input int len,
                               input logic [7:0] csum);
        logic [7:0]  e[$];
        logic [11:0] a;
        int          bad;
        e.push_back(8'h55);
        e.push_back(pid);
        for (int i = 0; i < len; i++) begin
            a = base + 12'(i);
            e.push_back(a[7:0]);
        end
        if (len > 0) e.push_back(csum);
        chk({tag, "_len"}, q.size(), e.size());
        bad = -1;
        for (int i = 0; i < e.size() && i < q.size(); i++)
            if (q[i] !== e[i] && bad < 0) bad = i;
        chk({tag, "_seq"}, bad, -1);
        if (len > 0)
            chk({tag, "_csum"}, (q.size() > 0) ? q[q.size()-1] : 8'hxx, csum);
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
        rst         = 1'b1;
        fs_tx       = 1'b0;
        tx_btype    = 4'h0;
        tx_ram_init = 12'h000;
        tx_ready    = 1'b1;
        repeat (3) tick;
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_fd", fd_tx, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_addr", ram_addr, 12'h000);
        rst = 1'b0;
        tick;

        run_frame(4'h1, 12'h000, 1'b0, 1'b0, 100, n);
        chk("ack_lat", n, 4);
        check_frame("ack", 8'hE1, 12'h000, 0, 8'h00);

        run_frame(4'h0, 12'h000, 1'b0, 1'b0, 100, n);
        chk("init_lat", n, 2);
        chk("init_nobytes", q.size(), 0);

        run_frame(4'h2, 12'h000, 1'b0, 1'b1, 100, n);
        check_frame("nak", 8'hD2, 12'h000, 0, 8'h00);

        run_frame(4'hF, 12'h000, 1'b0, 1'b0, 100, n);
        check_frame("undef", 8'h0F, 12'h000, 0, 8'h00);

        run_frame(4'hA, 12'h100, 1'b0, 1'b1, 200, n);
        check_frame("dtemp", 8'h5A, 12'h100, 16, 8'h5A);

        run_frame(4'h3, 12'hF00, 1'b0, 1'b0, 4000, n);
        check_frame("data0", 8'hC3, 12'hF00, 576, 8'hC3);
        chk("wrap_n", aq.size(), 577);
        chk("wrap_first", aq_at(0), 12'hF00);
        chk("wrap_top", aq_at(255), 12'hFFF);
        chk("wrap_zero", aq_at(256), 12'h000);
        chk("wrap_last", aq_at(575), 12'h13F);

        run_frame(4'h4, 12'h000, 1'b0, 1'b0, 4000, n);
        check_frame("data1", 8'hB4, 12'h000, 576, 8'hB4);
        q_full = q;
        stall_cnt = 0;
        run_frame(4'h4, 12'h000, 1'b1, 1'b0, 12000, n);
        check_frame("data1_thr", 8'hB4, 12'h000, 576, 8'hB4);
        chk("thr_len_eq", q.size(), q_full.size());
        bad = -1;
        for (int i = 0; i < q.size() && i < q_full.size(); i++)
            if (q[i] !== q_full[i] && bad < 0) bad = i;
        chk("thr_same_seq", bad, -1);
        chk("thr_stalled", stall_cnt > 0, 1'b1);

        q.delete();
        aq.delete();
        cap_en      = 1'b1;
        tx_btype    = 4'h3;
        tx_ram_init = 12'h000;
        fs_tx       = 1'b1;
        n = 0;
        while (q.size() < 7 && n < 200) begin
            tick;
            n++;
        end
        chk("rst_mid_reach", q.size(), 7);
        rst   = 1'b1;
        fs_tx = 1'b0;
        tick;
        chk("rst_mid_valid", tx_valid, 1'b0);
        chk("rst_mid_fd", fd_tx, 1'b0);
        chk("rst_mid_data", tx_data, 8'h00);
        rst = 1'b0;
        repeat (5) tick;
        chk("rst_mid_quiet", q.size(), 7);
        chk("rst_mid_idle", tx_valid, 1'b0);
        cap_en = 1'b0;
        tick;

        run_frame(4'h1, 12'h000, 1'b0, 1'b0, 100, n);
        chk("ack2_lat", n, 4);
        check_frame("ack2", 8'hE1, 12'h000, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx.md
USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 Parameter: SYNC_BYTE, default 8'h55, frame start byte.
REQ-002 Parameter: LEN_DATA, default 12'h240, payload byte count for BAG_DATA0/BAG_DATA1.
REQ-003 Parameter: LEN_PARAM, default 12'h010, payload byte count for BAG_DIDX..BAG_DTEMP (4'b0101-4'b1010).
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fs_tx  input  1  frame send request from the session controller.
REQ-007 fd_tx  output  1  frame send done.
REQ-008 tx_btype  input  4  bag type of the frame to send.
REQ-009 tx_ram_init  input  12  payload base address in the TX RAM.
REQ-010 ram_addr  output  12  TX RAM read address.
REQ-011 ram_rxd  input  8  TX RAM read data, valid one cycle after ram_addr.
REQ-012 tx_data  output  8  byte to the link PHY.
REQ-013 tx_valid  output  1  tx_data is valid.
REQ-014 tx_ready  input  1  PHY accepts the byte; a transfer occurs on a cycle with tx_valid && tx_ready.

Function
REQ-015 The FSM SHALL have states IDLE, PREP, SYNC, PID, RADDR, RWAIT, DATA, CSUM, DONE.
REQ-016 IDLE -> PREP when fs_tx=1; PREP latches tx_btype, tx_ram_init, clears byte counter and checksum.
REQ-017 PREP -> DONE if the latched btype is BAG_INIT (4'b0000); otherwise PREP -> SYNC.
REQ-018 SYNC: tx_data=SYNC_BYTE, tx_valid=1; advances to PID on transfer.
REQ-019 PID: tx_data={~btype,btype}, tx_valid=1; checksum loaded with the PID byte on transfer.
REQ-020 After the PID transfer: data btypes go to RADDR with length per REQ-002/REQ-003; all other btypes (ACK, NAK, STL, ERROR, undefined codes) go to DONE with no payload and no checksum byte.
REQ-021 RADDR: ram_addr=(base+count) mod 4096 (12-bit wrap); -> RWAIT.
REQ-022 RWAIT: register ram_rxd into the output byte; -> DATA.
REQ-023 DATA: tx_valid=1; on transfer, checksum ^= byte, count+1; -> CSUM if count+1==length, else -> RADDR.
REQ-024 CSUM: tx_data=checksum (XOR of PID and all payload bytes), tx_valid=1; -> DONE on transfer.
REQ-025 tx_data and tx_valid SHALL hold stable while tx_valid=1 and tx_ready=0; tx_valid=0 in IDLE, PREP, RADDR, RWAIT, DONE.
REQ-026 DONE: fd_tx=1; -> IDLE when fs_tx=0, else stay; fd_tx=0 in all other states.
REQ-027 fs_tx deasserting mid-frame SHALL NOT abort; the frame completes, then DONE lasts exactly one cycle if fs_tx is already 0.
REQ-028 tx_btype/tx_ram_init changes after PREP SHALL NOT affect the frame in progress.
REQ-029 Next frame SHALL NOT start until IDLE is re-entered (fs_tx must be seen low at DONE first).

Reset
REQ-030 With rst=1 on a clock edge: state=IDLE, fd_tx=0, tx_valid=0, tx_data=8'h00, ram_addr=12'h000, counter and checksum=0.
REQ-031 Reset asserted mid-frame SHALL drop tx_valid on the following cycle with no further bytes emitted.

Verification
REQ-032 ACK: fs_tx=1, tx_btype=4'b0001, tx_ready=1 -> bytes 8'h55, 8'hE1; fd_tx=1 until fs_tx drops; then IDLE.
REQ-033 BAG_INIT: tx_btype=4'b0000 -> no tx_valid; fd_tx asserted 2 cycles after fs_tx.
REQ-034 DTEMP, base 12'h100, RAM[n]=n -> 55, 5A, 16 bytes 00..0F, checksum 5A (XOR of 5A and 00..0F).
REQ-035 DATA0, base 12'hF00 -> 576 payload bytes; ram_addr wraps F00..FFF then 000..13F; checksum correct.
REQ-036 Random tx_ready throttling on DATA1 -> byte sequence identical to full-rate run; tx_data stable while stalled.
REQ-037 rst pulse after payload byte 5 of DATA0 -> tx_valid=0 next cycle, fd_tx=0; new ACK request then sends correctly.
